// File: rtl/conv_patch_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_patch_feeder_pkg
// Brief  : Shared kernel geometry and patch byte-order helper for the feeder.
// Rev    : 1.0
// ============================================================================
package conv_patch_feeder_pkg;

    localparam int c_PIX_W       = 8;
    localparam int c_CH          = 3;
    localparam int c_KSIZE       = 3;
    localparam int c_TAPS        = c_KSIZE * c_KSIZE;
    localparam int c_PATCH_BYTES = c_TAPS * c_CH;

    // Byte slot of channel c, kernel row ky, kernel column kx in a patch word.
    function automatic int tap_index(input int c, input int ky, input int kx);
        return c * c_TAPS + ky * c_KSIZE + kx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_patch_feeder_if.sv
`default_nettype none
// ============================================================================
// Module : conv_patch_feeder_if
// Brief  : Pixel-in / patch-out stream bundle of the conv patch feeder.
// Rev    : 1.0
// ============================================================================
interface conv_patch_feeder_if
    import conv_patch_feeder_pkg::*;
#(
    parameter int DATA_W = c_PIX_W,
    parameter int CH     = c_CH
);
    logic                         pix_valid_i;
    logic                         pix_ready_o;
    logic                         pix_sof_i;
    logic [CH*DATA_W-1:0]         pix_data_i;
    logic                         patch_valid_o;
    logic                         patch_ready_i;
    logic [c_TAPS*CH*DATA_W-1:0]  patch_data_o;
    logic                         patch_last_o;
    logic                         frame_done_o;

    modport master (
        output pix_valid_i, pix_sof_i, pix_data_i, patch_ready_i,
        input  pix_ready_o, patch_valid_o, patch_data_o, patch_last_o, frame_done_o
    );

    modport slave (
        input  pix_valid_i, pix_sof_i, pix_data_i, patch_ready_i,
        output pix_ready_o, patch_valid_o, patch_data_o, patch_last_o, frame_done_o
    );
endinterface
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// ============================================================================
// Module : conv_line_buf
// Brief  : Dual line buffer word {lb1, lb0}; async read, read-before-write.
// Rev    : 1.0
// ============================================================================
module conv_line_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic             clk_i,
    input  wire logic             wr_en_i,
    input  wire logic [AW-1:0]    addr_i,
    input  wire logic [WIDTH-1:0] wr_data_i,
    output logic      [WIDTH-1:0] rd_data_o
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign rd_data_o = r_mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[addr_i] <= wr_data_i;
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv_patch_feeder.sv
`default_nettype none
// ============================================================================
// Module : conv_patch_feeder
// Brief  : Raster pixel stream -> 3x3xCH sliding-window patches (stride 1).
// Rev    : 1.0
// ============================================================================
module conv_patch_feeder
    import conv_patch_feeder_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int DATA_W = c_PIX_W,
    parameter int CH     = c_CH
) (
    input  wire logic            clk_i,
    input  wire logic            rst_n,
    conv_patch_feeder_if.slave   bus
);
    localparam int c_PW = CH * DATA_W;
    localparam int c_XW = $clog2(IMG_W);
    localparam int c_YW = $clog2(IMG_H);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_H - 1);
    localparam logic [c_XW-1:0] c_X_TWO  = c_XW'(2);
    localparam logic [c_YW-1:0] c_Y_TWO  = c_YW'(2);

    logic [c_XW-1:0]          r_x;
    logic [c_YW-1:0]          r_y;
    logic                     r_patch_valid;
    logic                     r_patch_last;
    logic                     r_frame_done;
    logic [c_TAPS*c_PW-1:0]   r_patch_data;
    logic [c_PW-1:0]          r_win      [c_KSIZE][c_KSIZE];
    logic [c_PW-1:0]          w_win_next [c_KSIZE][c_KSIZE];
    logic [c_TAPS*c_PW-1:0]   w_patch;
    logic [2*c_PW-1:0]        w_lb_rd;
    logic [2*c_PW-1:0]        w_lb_wr;
    logic [c_XW-1:0]          w_x_eff;
    logic [c_YW-1:0]          w_y_eff;
    logic                     w_pix_ready;
    logic                     w_accept;
    logic                     w_emit;
    logic                     w_at_end;

    // A single output slot: new pixels flow only if the slot is free or retiring now.
    assign w_pix_ready = !r_patch_valid || bus.patch_ready_i;
    assign w_accept    = bus.pix_valid_i && w_pix_ready;

    // SOF re-anchors the beat to (0,0) regardless of where the counters were.
    assign w_x_eff  = bus.pix_sof_i ? '0 : r_x;
    assign w_y_eff  = bus.pix_sof_i ? '0 : r_y;
    assign w_emit   = (w_x_eff >= c_X_TWO) && (w_y_eff >= c_Y_TWO);
    assign w_at_end = (w_x_eff == c_X_LAST) && (w_y_eff == c_Y_LAST);

    // Upper half is the older row (lb1), lower half the newer row (lb0).
    assign w_lb_wr = {w_lb_rd[c_PW-1:0], bus.pix_data_i};

    conv_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (2 * c_PW),
        .AW    (c_XW)
    ) u_line_buf (
        .clk_i     (clk_i),
        .wr_en_i   (w_accept),
        .addr_i    (w_x_eff),
        .wr_data_i (w_lb_wr),
        .rd_data_o (w_lb_rd)
    );

    always_comb begin
        for (int ky = 0; ky < c_KSIZE; ky++) begin
            for (int kx = 0; kx < c_KSIZE - 1; kx++) begin
                w_win_next[ky][kx] = r_win[ky][kx+1];
            end
        end
        w_win_next[0][c_KSIZE-1] = w_lb_rd[2*c_PW-1:c_PW];
        w_win_next[1][c_KSIZE-1] = w_lb_rd[c_PW-1:0];
        w_win_next[2][c_KSIZE-1] = bus.pix_data_i;
    end

    always_comb begin
        w_patch = '0;
        for (int c = 0; c < CH; c++) begin
            for (int ky = 0; ky < c_KSIZE; ky++) begin
                for (int kx = 0; kx < c_KSIZE; kx++) begin
                    w_patch[tap_index(c, ky, kx)*DATA_W +: DATA_W] =
                        w_win_next[ky][kx][c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            for (int ky = 0; ky < c_KSIZE; ky++) begin
                for (int kx = 0; kx < c_KSIZE; kx++) begin
                    r_win[ky][kx] <= w_win_next[ky][kx];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_patch_valid <= 1'b0;
            r_patch_last  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_patch_data  <= '0;
        end else begin
            r_frame_done <= w_accept && w_at_end;
            if (w_accept) begin
                if (w_x_eff == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= w_at_end ? '0 : w_y_eff + 1'b1;
                end else begin
                    r_x <= w_x_eff + 1'b1;
                    r_y <= w_y_eff;
                end
            end
            if (w_accept && w_emit) begin
                r_patch_valid <= 1'b1;
                r_patch_data  <= w_patch;
                r_patch_last  <= w_at_end;
            end else if (bus.patch_ready_i) begin
                r_patch_valid <= 1'b0;
                r_patch_last  <= 1'b0;
            end
        end
    end

    assign bus.pix_ready_o   = w_pix_ready;
    assign bus.patch_valid_o = r_patch_valid;
    assign bus.patch_data_o  = r_patch_data;
    assign bus.patch_last_o  = r_patch_last;
    assign bus.frame_done_o  = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_conv_patch_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_patch_feeder
// Brief  : Directed + randomised-handshake bench for conv_patch_feeder.
// Rev    : 1.0
// ============================================================================
module tb_conv_patch_feeder;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done4 = 0;
    int   done16 = 0;
    int   pcnt16 = 0;
    bit   rnd_en = 0;
    logic [216:0] q4  [$];
    logic [216:0] q16 [$];
    logic [216:0] e4;
    logic [216:0] e16;

    conv_patch_feeder_if #(.DATA_W(8), .CH(3)) bus4 ();
    conv_patch_feeder_if #(.DATA_W(8), .CH(3)) bus16 ();

    conv_patch_feeder #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .CH(3)) u_dut4 (
        .clk_i (clk), .rst_n (rst_n), .bus (bus4)
    );
    conv_patch_feeder #(.IMG_W(16), .IMG_H(16), .DATA_W(8), .CH(3)) u_dut16 (
        .clk_i (clk), .rst_n (rst_n), .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int n, input int f);
        logic [23:0] v;
        for (int c = 0; c < 3; c++) v[c*8 +: 8] = 8'(n + 16*c + f);
        return v;
    endfunction

    // Expected patch for output position (x,y): kernel tap (ky,kx) is pixel (x-2+kx, y-2+ky).
    function automatic logic [215:0] exp_patch(input int w, input int x, input int y, input int f);
        logic [215:0] p;
        logic [23:0]  px;
        p = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                px = pix((y - 2 + ky) * w + (x - 2 + kx), f);
                for (int c = 0; c < 3; c++) p[(c*9 + ky*3 + kx)*8 +: 8] = px[c*8 +: 8];
            end
        end
        return p;
    endfunction

    task automatic push_frame(input int w, input int h, input int f, input bit big);
        logic [216:0] e;
        for (int y = 2; y < h; y++) begin
            for (int x = 2; x < w; x++) begin
                e = {(x == w-1 && y == h-1), exp_patch(w, x, y, f)};
                if (big) q16.push_back(e); else q4.push_back(e);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic send4(input int n, input bit sof);
        bus4.pix_valid_i = 1'b1;
        bus4.pix_sof_i   = sof;
        bus4.pix_data_i  = pix(n, 0);
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (bus4.pix_ready_o) begin
                @(posedge clk); #1;
                bus4.pix_valid_i = 1'b0;
                bus4.pix_sof_i   = 1'b0;
                return;
            end
        end
        check("send4_timeout", 0, 1);
        bus4.pix_valid_i = 1'b0;
        bus4.pix_sof_i   = 1'b0;
    endtask

    task automatic send16(input int n, input bit sof, input int f);
        if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
        end
        bus16.pix_valid_i = 1'b1;
        bus16.pix_sof_i   = sof;
        bus16.pix_data_i  = pix(n, f);
        for (int t = 0; t < 256; t++) begin
            @(negedge clk);
            if (bus16.pix_ready_o) begin
                @(posedge clk); #1;
                bus16.pix_valid_i = 1'b0;
                bus16.pix_sof_i   = 1'b0;
                return;
            end
        end
        check("send16_timeout", 0, 1);
        bus16.pix_valid_i = 1'b0;
        bus16.pix_sof_i   = 1'b0;
    endtask

    task automatic drain(input string tag, input bit big);
        for (int t = 0; t < 200; t++) begin
            if ((big ? q16.size() : q4.size()) == 0) break;
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        check(tag, big ? q16.size() : q4.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus4.patch_valid_o && bus4.patch_ready_i) begin
            if (q4.size() == 0) check("dut4_extra_patch", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("dut4_patch", bus4.patch_data_o, e4[215:0]);
                check("dut4_last", bus4.patch_last_o, e4[216]);
            end
        end
        if (bus4.frame_done_o) done4++;
    end

    always @(negedge clk) begin
        if (rst_n && bus16.patch_valid_o && bus16.patch_ready_i) begin
            if (q16.size() == 0) check("dut16_extra_patch", 1, 0);
            else begin
                e16 = q16.pop_front();
                pcnt16++;
                check("dut16_patch", bus16.patch_data_o, e16[215:0]);
                check("dut16_last", bus16.patch_last_o, e16[216]);
            end
        end
        if (bus16.frame_done_o) done16++;
    end

    initial begin
        bus16.patch_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus16.patch_ready_i = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [215:0] pd;
        bit exp_v;
        int d0;

        rst_n = 1'b0;
        bus4.pix_valid_i = 1'b0; bus4.pix_sof_i = 1'b0; bus4.pix_data_i = '0; bus4.patch_ready_i = 1'b1;
        bus16.pix_valid_i = 1'b0; bus16.pix_sof_i = 1'b0; bus16.pix_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus4.patch_valid_o, 0);
        check("rst_last",  bus4.patch_last_o, 0);
        check("rst_done",  bus4.frame_done_o, 0);
        check("rst_data",  bus4.patch_data_o, 0);
        check("rst_ready", bus4.pix_ready_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 1: one frame, exact patch timing and hand-computed bytes.
        push_frame(4, 4, 0, 0);
        d0 = done4;
        bus4.pix_valid_i = 1'b1; bus4.pix_sof_i = 1'b1; bus4.pix_data_i = pix(0, 0);
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            bus4.pix_sof_i = 1'b0;
            if (n < 15) bus4.pix_data_i = pix(n + 1, 0);
            else bus4.pix_valid_i = 1'b0;
            @(negedge clk);
            exp_v = (n == 10 || n == 11 || n == 14 || n == 15);
            check("t1_valid", bus4.patch_valid_o, exp_v);
            check("t1_done", bus4.frame_done_o, n == 15);
            if (exp_v) check("t1_last", bus4.patch_last_o, n == 15);
            if (n == 10) begin
                pd = bus4.patch_data_o;
                check("t1_byte0",  pd[7:0],     0);
                check("t1_byte4",  pd[39:32],   5);
                check("t1_byte8",  pd[71:64],   10);
                check("t1_byte9",  pd[79:72],   16);
                check("t1_byte26", pd[215:208], 42);
            end
        end
        @(posedge clk); #1;
        drain("t1_drain", 0);
        check("t1_frame_done_cnt", done4 - d0, 1);

        // Test 2: backpressure on the first patch with a pixel waiting.
        push_frame(4, 4, 0, 0);
        d0 = done4;
        bus4.patch_ready_i = 1'b0;
        for (int n = 0; n <= 10; n++) send4(n, n == 0);
        bus4.pix_valid_i = 1'b1; bus4.pix_data_i = pix(11, 0);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("t2_stall_ready", bus4.pix_ready_o, 0);
            check("t2_stall_valid", bus4.patch_valid_o, 1);
            check("t2_stall_data",  bus4.patch_data_o, exp_patch(4, 2, 2, 0));
        end
        @(posedge clk); #1;
        bus4.patch_ready_i = 1'b1;
        for (int n = 11; n < 16; n++) send4(n, 1'b0);
        drain("t2_drain", 0);
        check("t2_frame_done_cnt", done4 - d0, 1);

        // Test 3: two back-to-back frames.
        push_frame(4, 4, 0, 0);
        push_frame(4, 4, 0, 0);
        d0 = done4;
        for (int n = 0; n < 32; n++) send4(n % 16, (n % 16) == 0);
        drain("t3_drain", 0);
        check("t3_frame_done_cnt", done4 - d0, 2);

        // Test 4: resync after a 6-beat partial frame.
        push_frame(4, 4, 0, 0);
        d0 = done4;
        for (int n = 0; n < 6; n++) send4(n, n == 0);
        for (int n = 0; n < 16; n++) send4(n, n == 0);
        drain("t4_drain", 0);
        check("t4_frame_done_cnt", done4 - d0, 1);

        // Test 5: reset with a patch pending; next frame needs no SOF.
        q4.push_back({1'b0, exp_patch(4, 2, 2, 0)});
        d0 = done4;
        for (int n = 0; n < 12; n++) send4(n, n == 0);
        bus4.patch_ready_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus4.patch_ready_i = 1'b1;
        @(negedge clk);
        check("t5_dropped_valid", bus4.patch_valid_o, 0);
        check("t5_dropped_last",  bus4.patch_last_o, 0);
        @(posedge clk); #1;
        push_frame(4, 4, 0, 0);
        for (int n = 0; n < 16; n++) send4(n, 1'b0);
        drain("t5_drain", 0);
        check("t5_frame_done_cnt", done4 - d0, 1);

        // Test 6: 16x16, three frames, random valid gaps and ready.
        d0 = done16;
        rnd_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame(16, 16, f * 5, 1);
            for (int n = 0; n < 256; n++) send16(n, n == 0, f * 5);
        end
        rnd_en = 1'b0;
        drain("t6_drain", 1);
        check("t6_patch_cnt", pcnt16, 3 * 196);
        check("t6_frame_done_cnt", done16 - d0, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
